md_sched: RTL and testbench

Multi-cycle multiply/divide scheduler for the Execute stage. It accepts a multiply, divide or HI/LO-move request from the E-stage control alongside the forwarded ALU operands, and owns the HI/LO registers. It sequences the fixed-latency operation with a down-counter and raises a stall request so the hazard logic freezes D/F while a later instruction needs the unit.

---
 rtl/md_sched_pkg.sv | 15 +
 rtl/md_sched.sv | 124 ++++++++++++
 tb/tb_md_sched.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/md_sched_pkg.sv
// Shared control constants for the multiply/divide unit: MDOpE encodings used by
// the controller, the hazard unit and md_sched.
package md_sched_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

endpackage

// File: rtl/md_sched.sv
// Multi-cycle multiply/divide scheduler for the E stage: owns HI/LO, sequences a
// fixed-latency operation with a down-counter and requests D/F stalls.
module md_sched
  import md_sched_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDOpE,
  input  logic        MDUseD,
  output logic        Busy,
  output logic        StallMD,
  output logic [31:0] MDOut
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  state_t      state, state_n;
  logic [3:0]  count, count_n;
  logic [31:0] hi, lo, pend_hi, pend_lo;
  logic [31:0] hi_n, lo_n, pend_hi_n, pend_lo_n;

  logic        is_mul, is_div, start;
  logic [63:0] prod_s, prod_u;
  logic [31:0] divisor, quo_s, rem_s, quo_u, rem_u;

  assign is_mul = (MDOpE == MD_MULT) || (MDOpE == MD_MULTU);
  assign is_div = (MDOpE == MD_DIV)  || (MDOpE == MD_DIVU);
  assign start  = (is_mul || is_div) && (state == S_IDLE);

  // Low 64 bits of the product of sign-extended operands is the signed product.
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Divisor forced to 1 when B is zero so the divider never yields X; that result is discarded.
  assign divisor = (B == 32'd0) ? 32'd1 : B;
  assign quo_s   = $signed(A) / $signed(divisor);
  assign rem_s   = $signed(A) % $signed(divisor);
  assign quo_u   = A / divisor;
  assign rem_u   = A % divisor;

  // NOTE: every variable is given its hold value first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_n   = state;
    count_n   = count;
    hi_n      = hi;
    lo_n      = lo;
    pend_hi_n = pend_hi;
    pend_lo_n = pend_lo;
    if (state == S_IDLE) begin
      if (start) begin
        state_n = S_RUN;
        if (is_mul) begin
          count_n = MULT_N;
          {pend_hi_n, pend_lo_n} = (MDOpE == MD_MULT) ? prod_s : prod_u;
        end else begin
          count_n = DIV_N;
          if (B == 32'd0) begin
            // Divide by zero retires the current HI/LO, which cannot change while running.
            pend_hi_n = hi;
            pend_lo_n = lo;
          end else if (MDOpE == MD_DIV) begin
            pend_hi_n = rem_s;
            pend_lo_n = quo_s;
          end else begin
            pend_hi_n = rem_u;
            pend_lo_n = quo_u;
          end
        end
      end else if (MDOpE == MD_MTHI) begin
        hi_n = A;
      end else if (MDOpE == MD_MTLO) begin
        lo_n = A;
      end
    end else begin
      count_n = count - 4'd1;
      if (count == 4'd1) begin
        state_n = S_IDLE;
        hi_n    = pend_hi;
        lo_n    = pend_lo;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the datapath registers are reset too, so an aborted operation leaves no partial result behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      count   <= 4'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
    end else begin
      state   <= state_n;
      count   <= count_n;
      hi      <= hi_n;
      lo      <= lo_n;
      pend_hi <= pend_hi_n;
      pend_lo <= pend_lo_n;
    end
  end

  assign Busy    = (state == S_RUN);
  assign StallMD = MDUseD && (Busy || start);

  always_comb begin
    MDOut = 32'd0;
    if (MDOpE == MD_MFHI) MDOut = hi;
    else if (MDOpE == MD_MFLO) MDOut = lo;
  end

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: expected HI/LO results are queued at issue and
// compared when the unit drops Busy; stall, busy-length and reset behaviour checked inline.
module tb_md_sched;
  import md_sched_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [3:0]  MDOpE;
  logic        MDUseD;
  logic        Busy, StallMD;
  logic [31:0] MDOut;

  always #5 clk = ~clk;

  md_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .MDOpE(MDOpE), .MDUseD(MDUseD),
    .Busy(Busy), .StallMD(StallMD), .MDOut(MDOut)
  );

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic use_d);
    MDOpE  = op;
    A      = a;
    B      = b;
    MDUseD = use_d;
    #2;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    drive(MD_MFLO, 32'd0, 32'd0, 1'b0);
    check({tag, "_lo"}, MDOut, exp_lo);
    next_cycle();
    drive(MD_MFHI, 32'd0, 32'd0, 1'b0);
    check({tag, "_hi"}, MDOut, exp_hi);
    next_cycle();
  endtask

  // Issue op in the current cycle with an MD instruction waiting in D, hold E idle
  // (or inject illegal MD ops) while busy, then read back LO/HI in the first idle cycle.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int ncyc, input bit intrude);
    exp_t e;
    int   busy_cnt;
    logic use_d;
    busy_cnt = 0;
    sb.push_back('{tag, exp_hi, exp_lo, ncyc});
    drive(op, a, b, 1'b1);
    check({tag, "_stall_start"}, 32'(StallMD), 32'd1);
    check({tag, "_busy_start"}, 32'(Busy), 32'd0);
    next_cycle();
    for (int i = 0; i < 20; i++) begin
      use_d = (busy_cnt != 2);
      if (intrude && busy_cnt == 1)      drive(MD_DIV, 32'hFFFF_FF9C, 32'd3, 1'b1);
      else if (intrude && busy_cnt == 2) drive(MD_MTHI, 32'hDEAD, 32'd0, 1'b1);
      else if (intrude && busy_cnt == 3) drive(MD_MTLO, 32'hBEEF, 32'd0, 1'b1);
      else                               drive(MD_NONE, $urandom, $urandom, use_d);
      if (!Busy) break;
      check({tag, "_stall_busy"}, 32'(StallMD), 32'(MDUseD));
      busy_cnt++;
      next_cycle();
    end
    e = sb.pop_front();
    check({e.tag, "_busy_cycles"}, 32'(busy_cnt), 32'(e.cycles));
    drive(MD_MFLO, 32'd0, 32'd0, 1'b0);
    check({e.tag, "_stall_after"}, 32'(StallMD), 32'd0);
    check({e.tag, "_lo"}, MDOut, e.lo);
    next_cycle();
    drive(MD_MFHI, 32'd0, 32'd0, 1'b0);
    check({e.tag, "_hi"}, MDOut, e.hi);
    next_cycle();
  endtask

  initial begin
    int cnt;
    reset  = 1'b0;
    MDOpE  = MD_NONE;
    A      = 32'd0;
    B      = 32'd0;
    MDUseD = 1'b0;
    #3;
    check("reset_busy", 32'(Busy), 32'd0);
    drive(MD_MFHI, 32'd0, 32'd0, 1'b0);
    check("reset_mdout_hi", MDOut, 32'd0);
    next_cycle();
    next_cycle();
    reset = 1'b1;
    drive(MD_MFLO, 32'd0, 32'd0, 1'b0);
    check("reset_mdout_lo", MDOut, 32'd0);
    next_cycle();

    // MTHI/MTLO visible the following cycle.
    drive(MD_MTHI, 32'h1234, 32'd0, 1'b0);
    next_cycle();
    drive(MD_MFHI, 32'd0, 32'd0, 1'b0);
    check("mthi_visible", MDOut, 32'h1234);
    next_cycle();
    drive(MD_MTLO, 32'h5678, 32'd0, 1'b0);
    next_cycle();
    drive(MD_MFLO, 32'd0, 32'd0, 1'b0);
    check("mtlo_visible", MDOut, 32'h5678);
    next_cycle();

    // Reset asserted in the third busy cycle of a MULT.
    drive(MD_MULT, 32'd3, 32'd4, 1'b0);
    next_cycle();
    drive(MD_NONE, 32'd0, 32'd0, 1'b0);
    check("midrun_busy1", 32'(Busy), 32'd1);
    next_cycle();
    next_cycle();
    reset = 1'b0;
    drive(MD_MFHI, 32'd0, 32'd0, 1'b1);
    check("midrun_rst_busy", 32'(Busy), 32'd0);
    check("midrun_rst_hi", MDOut, 32'd0);
    check("midrun_rst_stall", 32'(StallMD), 32'd0);
    drive(MD_MFLO, 32'd0, 32'd0, 1'b0);
    check("midrun_rst_lo", MDOut, 32'd0);
    next_cycle();
    reset = 1'b1;
    drive(MD_NONE, 32'd0, 32'd0, 1'b0);
    repeat (6) next_cycle();
    check("midrun_post_busy", 32'(Busy), 32'd0);
    read_hilo("midrun_post", 32'd0, 32'd0);

    // Arithmetic and stall windows.
    run_op("mult",  MD_MULT,  32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MC, 1'b0);
    run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, MC, 1'b0);
    run_op("div",   MD_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DC, 1'b0);

    // Divide by zero keeps HI/LO.
    drive(MD_MTHI, 32'h55, 32'd0, 1'b0);
    next_cycle();
    drive(MD_MTLO, 32'h55, 32'd0, 1'b0);
    next_cycle();
    run_op("divu0", MD_DIVU, 32'd7, 32'd0, 32'h55, 32'h55, DC, 1'b0);

    // Illegal MD ops while running are ignored.
    run_op("intrude", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, DC, 1'b1);

    // Back-to-back: second start in the first idle cycle.
    drive(MD_MULT, 32'd3, 32'd5, 1'b0);
    next_cycle();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      drive(MD_NONE, 32'd0, 32'd0, 1'b0);
      if (!Busy) break;
      cnt++;
      next_cycle();
    end
    check("b2b_first_cycles", 32'(cnt), 32'(MC));
    run_op("b2b", MD_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, MC, 1'b0);

    if (sb.size() != 0) check("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
